seq_det_scan_ctrl: RTL and testbench

//  Scan controller for the serial sequence detector. Accepts parallel words over a valid/ready handshake.

---
 rtl/seq_det_pkg.sv | 22 ++
 rtl/seq_det_prog_core.sv | 61 ++++++
 rtl/seq_det_scan_ctrl.sv | 128 ++++++++++++
 tb/tb_seq_det_scan_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and reset constants for the sequence-detector scan controller.
package seq_det_pkg;

  localparam int unsigned LEN_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } state_e;

  localparam logic [7:0]       DEF_PATTERN = 8'b101;
  localparam logic [LEN_W-1:0] DEF_LEN     = LEN_W'(3);
  localparam logic             DEF_OVERLAP = 1'b1;

  // Limit a requested pattern length to what the detector core can hold.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                 input logic [LEN_W-1:0] max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/seq_det_prog_core.sv
// Programmable Mealy pattern detector: bit history plus a combinational match on the live bit.
module seq_det_prog_core
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_W_MAX = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic                 shift_en_i,
  input  logic                 x_i,
  input  logic [PAT_W_MAX-1:0] pattern_i,
  input  logic [LEN_W-1:0]     len_i,
  input  logic                 overlap_i,
  output logic                 hit_o
);

  localparam int unsigned SEEN_W = $clog2(PAT_W_MAX + 1);
  localparam int unsigned CMP_W  = SEEN_W + LEN_W;

  logic [PAT_W_MAX-1:0] hist_q, hist_d;
  logic [SEEN_W-1:0]    seen_q, seen_d;
  logic [PAT_W_MAX-1:0] window;
  logic [PAT_W_MAX-1:0] mask;
  logic                 enough;

  // Newest bit sits in the LSB, matching the pattern orientation.
  assign window = {hist_q[PAT_W_MAX-2:0], x_i};
  assign mask   = (PAT_W_MAX'(1) << len_i) - PAT_W_MAX'(1);
  assign enough = (CMP_W'(seen_q) + CMP_W'(1)) >= CMP_W'(len_i);
  assign hit_o  = shift_en_i && (len_i != '0) && enough &&
                  (((window ^ pattern_i) & mask) == '0);

  always_comb begin
    hist_d = hist_q;
    seen_d = seen_q;
    if (clr_i) begin
      hist_d = '0;
      seen_d = '0;
    end else if (shift_en_i) begin
      if (hit_o && !overlap_i) begin
        hist_d = '0;
        seen_d = '0;
      end else begin
        hist_d = window;
        if (seen_q != SEEN_W'(PAT_W_MAX)) seen_d = seen_q + SEEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      seen_q <= '0;
    end else begin
      hist_q <= hist_d;
      seen_q <= seen_d;
    end
  end

endmodule

// File: rtl/seq_det_scan_ctrl.sv
// Scan controller: accepts words, serializes them MSB-first into the detector,
// and reports hit count and first-hit index per word.
module seq_det_scan_ctrl
  import seq_det_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned PAT_W_MAX = 8,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_we,
  input  logic [PAT_W_MAX-1:0]      cfg_pattern,
  input  logic [LEN_W-1:0]          cfg_len,
  input  logic                      cfg_overlap,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      in_ready,
  output logic                      busy,
  output logic                      x_out,
  output logic                      hit,
  output logic                      out_valid,
  output logic [CNT_W-1:0]          out_count,
  output logic [$clog2(DATA_W)-1:0] out_first,
  input  logic                      out_ready
);

  localparam int unsigned IDX_W = $clog2(DATA_W);

  state_e               state_q, state_d;
  logic [DATA_W-1:0]    sreg_q, sreg_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     first_q, first_d;
  logic [PAT_W_MAX-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic                 ovl_q, ovl_d;
  logic                 accept;
  logic                 shifting;

  assign accept   = (state_q == IDLE) && in_valid;
  assign shifting = (state_q == SHIFT);

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == REPORT);
  assign x_out     = shifting && sreg_q[DATA_W-1];
  assign out_count = cnt_q;
  assign out_first = first_q;

  seq_det_prog_core #(
    .PAT_W_MAX (PAT_W_MAX)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (accept),
    .shift_en_i (shifting),
    .x_i        (x_out),
    .pattern_i  (pat_q),
    .len_i      (len_q),
    .overlap_i  (ovl_q),
    .hit_o      (hit)
  );

  // Next-state, datapath and config updates.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    unique case (state_q)
      IDLE: begin
        if (cfg_we) begin
          pat_d = cfg_pattern;
          len_d = clamp_len(cfg_len, LEN_W'(PAT_W_MAX));
          ovl_d = cfg_overlap;
        end
        if (in_valid) begin
          sreg_d  = in_data;
          idx_d   = '0;
          cnt_d   = '0;
          first_d = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sreg_d = sreg_q << 1;
        idx_d  = idx_q + IDX_W'(1);
        if (hit) begin
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == '0) first_d = idx_q;
        end
        if (idx_q == IDX_W'(DATA_W - 1)) state_d = REPORT;
      end
      REPORT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      first_q <= '0;
      pat_q   <= PAT_W_MAX'(DEF_PATTERN);
      len_q   <= DEF_LEN;
      ovl_q   <= DEF_OVERLAP;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
    end
  end

endmodule

// File: tb/tb_seq_det_scan_ctrl.sv
// Directed bench for seq_det_scan_ctrl with hand-computed hit counts, first indices and hit masks.
module tb_seq_det_scan_ctrl;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned PAT_W_MAX = 8;
  localparam int unsigned CNT_W     = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 cfg_we;
  logic [PAT_W_MAX-1:0] cfg_pattern;
  logic [3:0]           cfg_len;
  logic                 cfg_overlap;
  logic                 in_valid;
  logic [DATA_W-1:0]    in_data;
  logic                 in_ready;
  logic                 busy;
  logic                 x_out;
  logic                 hit;
  logic                 out_valid;
  logic [CNT_W-1:0]     out_count;
  logic [3:0]           out_first;
  logic                 out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seq_det_scan_ctrl #(
    .DATA_W    (DATA_W),
    .PAT_W_MAX (PAT_W_MAX),
    .CNT_W     (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .busy        (busy),
    .x_out       (x_out),
    .hit         (hit),
    .out_valid   (out_valid),
    .out_count   (out_count),
    .out_first   (out_first),
    .out_ready   (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scan one word; emask bit k marks a hit on bit index k (0 = MSB).
  task automatic scan(input string tag, input logic [15:0] w, input bit we,
                      input logic [7:0] pat, input logic [3:0] len, input bit ovl,
                      input logic [7:0] ecnt, input logic [3:0] efirst,
                      input logic [15:0] emask, input int stall, input bit busy_cfg);
    logic [15:0] xw;
    logic [15:0] hmask;
    bit          ov_early;
    xw = '0; hmask = '0; ov_early = 0;
    @(negedge clk);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_data = w;
    cfg_we = we; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; cfg_we = 1'b0; in_data = '0;
    for (int k = 0; k < 16; k++) begin
      xw[15-k] = x_out;
      if (hit) hmask[k] = 1'b1;
      if (out_valid || !busy) ov_early = 1;
      if (busy_cfg && k == 3) begin
        cfg_we = 1'b1; cfg_pattern = 8'h0F; cfg_len = 4'd4; cfg_overlap = 1'b0;
      end else begin
        cfg_we = 1'b0;
      end
      @(negedge clk);
    end
    cfg_we = 1'b0;
    chk({tag, "_x_stream"}, 32'(xw), 32'(w));
    chk({tag, "_hit_mask"}, 32'(hmask), 32'(emask));
    chk({tag, "_early_valid"}, 32'(ov_early), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_count"}, 32'(out_count), 32'(ecnt));
    chk({tag, "_first"}, 32'(out_first), 32'(efirst));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_stall_count"}, 32'(out_count), 32'(ecnt));
      chk({tag, "_stall_first"}, 32'(out_first), 32'(efirst));
      chk({tag, "_stall_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_idle_after"}, 32'({in_ready, out_valid}), 32'b10);
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_hit", 32'(hit), 32'd0);
    chk("rst_x_out", 32'(x_out), 32'd0);
    chk("rst_count_first", 32'({out_count, out_first}), 32'd0);

    scan("t1_0005", 16'h0005, 0, 8'h00, 4'd0, 0, 8'd1, 4'd15, 16'h8000, 0, 0);
    scan("t2_a5a5", 16'hA5A5, 0, 8'h00, 4'd0, 0, 8'd4, 4'd2, 16'h8484, 0, 0);
    scan("t3_ovl", 16'hA800, 1, 8'h05, 4'd3, 1, 8'd2, 4'd2, 16'h0014, 0, 0);
    scan("t3_novl", 16'hA800, 1, 8'h05, 4'd3, 0, 8'd1, 4'd2, 16'h0004, 0, 0);
    scan("t4_ovl", 16'hFFFF, 1, 8'h0F, 4'd4, 1, 8'd13, 4'd3, 16'hFFF8, 0, 0);
    scan("t4_novl", 16'hFFFF, 1, 8'h0F, 4'd4, 0, 8'd4, 4'd3, 16'h8888, 0, 0);
    scan("t4_len0", 16'hFFFF, 1, 8'h0F, 4'd0, 1, 8'd0, 4'd0, 16'h0000, 0, 0);
    scan("clamp15", 16'hFFFF, 1, 8'hFF, 4'd15, 1, 8'd9, 4'd7, 16'hFF80, 0, 0);

    scan("t5_stall", 16'hA5A5, 1, 8'h05, 4'd3, 1, 8'd4, 4'd2, 16'h8484, 5, 1);
    scan("t5_cfg_kept", 16'hA5A5, 0, 8'h00, 4'd0, 0, 8'd4, 4'd2, 16'h8484, 0, 0);

    // Abort a word with a non-default config after bit 7 is presented.
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'hFFFF;
    cfg_we = 1'b1; cfg_pattern = 8'h0F; cfg_len = 4'd4; cfg_overlap = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; cfg_we = 1'b0;
    repeat (7) @(negedge clk);
    chk("t6_hit_bit7", 32'(hit), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("t6_in_ready", 32'(in_ready), 32'd1);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_hit", 32'(hit), 32'd0);
    chk("t6_out_valid", 32'(out_valid), 32'd0);
    repeat (10) @(negedge clk);
    chk("t6_no_valid_later", 32'(out_valid), 32'd0);
    scan("t6_defaults", 16'h0005, 0, 8'h00, 4'd0, 0, 8'd1, 4'd15, 16'h8000, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
